addsub_seq: RTL

//  Multi-precision add/subtract sequencer. Accepts WIDTH*WORDS-bit operands,

---
 rtl/addsub_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Multi-precision add/subtract sequencer: walks WIDTH*WORDS-bit operands through
// one narrow addsub datapath, least-significant word first, chaining carry/borrow.

module addsub_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] ext;

  // Subtract reports borrow-out directly; add reports the inverted carry-out.
  always_comb begin
    if (sub_i) ext = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
    else       ext = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    sum_o  = ext[WIDTH-1:0];
    cout_o = sub_i ? ext[WIDTH] : ~ext[WIDTH];
  end
endmodule

module addsub_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic                   cin,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH*WORDS-1:0] result,
  output logic                   carry_out,
  output logic                   overflow
);
  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d, result_q, result_d;
  logic               op_sub_q, op_sub_d, chain_q, chain_d;
  logic               carry_q, carry_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   word_a, word_b, word_sum;
  logic               word_cout, chain_next, accept, last_word;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_word = (idx_q == IDX_W'(WORDS - 1));
  assign word_a    = a_q[int'(idx_q)*WIDTH +: WIDTH];
  assign word_b    = b_q[int'(idx_q)*WIDTH +: WIDTH];

  addsub_unit #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (word_a),
    .b_i   (word_b),
    .sub_i (op_sub_q),
    .cin_i (chain_q),
    .sum_o (word_sum),
    .cout_o(word_cout)
  );

  // Undo the datapath's inverted add carry so the chain always holds true carry/borrow.
  assign chain_next = word_cout ^ ~op_sub_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_word) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // NOTE: every comb output gets a default up front so no path leaves it unassigned (no latch).
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_sub_d = op_sub_q;
    chain_d  = chain_q;
    idx_d    = idx_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      op_sub_d = op_sub;
      chain_d  = cin;
      idx_d    = '0;
    end else if (state_q == S_RUN) begin
      result_d[int'(idx_q)*WIDTH +: WIDTH] = word_sum;
      chain_d = chain_next;
      idx_d   = IDX_W'(idx_q + 1'b1);
      if (last_word) begin
        carry_d = chain_next;
        if (op_sub_q) ovf_d = (a_q[N-1] != b_q[N-1]) && (word_sum[WIDTH-1] != a_q[N-1]);
        else          ovf_d = (a_q[N-1] == b_q[N-1]) && (word_sum[WIDTH-1] != a_q[N-1]);
      end
    end
  end

  // NOTE: operand and result storage is reset too, since an abort must leave nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_sub_q <= 1'b0;
      chain_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_sub_q <= op_sub_d;
      chain_q  <= chain_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
endmodule
